// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU operand feeder: FSM states,
// sign-magnitude helpers and the FIFO entry layout.
package tpu_pkg;

   localparam int SM_WIDTH = 8;
   localparam logic [SM_WIDTH-1:0] SM_NEG_ZERO = 8'h80;

   typedef enum logic [1:0] {
      ST_FEED   = 2'd0,
      ST_STROBE = 2'd1,
      ST_CLEAR  = 2'd2
   } feeder_state_t;

   typedef struct packed {
      logic [SM_WIDTH-1:0] a;
      logic [SM_WIDTH-1:0] b;
      logic                last;
   } fifo_entry_t;

   // The MAC treats -0 and +0 differently in its sign logic, so only +0 is sent.
   function automatic logic [SM_WIDTH-1:0] sm_norm(input logic [SM_WIDTH-1:0] v);
      return (v == SM_NEG_ZERO) ? '0 : v;
   endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Operand-pair FIFO for the feeder; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
import tpu_pkg::*;

module feeder_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  fifo_entry_t i_entry,
   input  logic        i_pop,
   output fifo_entry_t o_entry,
   output logic        o_full,
   output logic        o_empty
);

   localparam int AW = $clog2(DEPTH);

   fifo_entry_t r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_push;
   logic        w_pop;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_entry = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/tpu_operand_feeder.sv
// Feeds buffered sign-magnitude operand pairs to the MAC and sequences the
// result strobe / accumulator clear. Optional macro: FEEDER_STALL_CNT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_FEED   | pop one pair per cycle when available and not held
// ST_STROBE | last pair issued; out_HL asserted on the following cycle
// ST_CLEAR  | acc_clear asserted on the following cycle; back to FEED
import tpu_pkg::*;

module tpu_operand_feeder #(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SM_WIDTH-1:0] in_a,
   input  logic [SM_WIDTH-1:0] in_b,
   input  logic                in_last,
   input  logic                hold,
   output logic [SM_WIDTH-1:0] input1,
   output logic [SM_WIDTH-1:0] input2,
   output logic                out_HL,
   output logic                acc_clear,
   output logic [15:0]         stall_cnt
);

   feeder_state_t       r_state;
   feeder_state_t       w_state_nxt;
   fifo_entry_t         w_in_entry;
   fifo_entry_t         w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic [SM_WIDTH-1:0] r_input1;
   logic [SM_WIDTH-1:0] r_input2;
   logic                r_out_hl;
   logic                r_acc_clear;

   assign w_in_entry = '{a: in_a, b: in_b, last: in_last};
   assign in_ready   = !w_full;

   feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (in_valid && in_ready),
      .i_entry (w_in_entry),
      .i_pop   (w_pop),
      .o_entry (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_FEED;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_FEED: begin
            if (!w_empty && !hold) begin
               w_pop = 1'b1;
               if (w_head.last) w_state_nxt = ST_STROBE;
            end
         end
         ST_STROBE: w_state_nxt = ST_CLEAR;
         ST_CLEAR:  w_state_nxt = ST_FEED;
         default:   w_state_nxt = ST_FEED;
      endcase
   end

   // Strobe and clear lag their state by one register so they never share a
   // cycle with the operands of the last pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_input1    <= '0;
         r_input2    <= '0;
         r_out_hl    <= 1'b0;
         r_acc_clear <= 1'b0;
      end else begin
         r_input1    <= w_pop ? sm_norm(w_head.a) : '0;
         r_input2    <= w_pop ? sm_norm(w_head.b) : '0;
         r_out_hl    <= (r_state == ST_STROBE);
         r_acc_clear <= (r_state == ST_CLEAR);
      end
   end

   assign input1    = r_input1;
   assign input2    = r_input2;
   assign out_HL    = r_out_hl;
   assign acc_clear = r_acc_clear;

`ifdef FEEDER_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if ((r_state == ST_FEED) && w_empty && !hold &&
                   (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Self-checking bench for tpu_operand_feeder: directed scenarios plus random
// traffic against a queue-based reference model of the feeder.
module tb_tpu_operand_feeder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        in_last;
   logic        hold;
   logic [7:0]  input1;
   logic [7:0]  input2;
   logic        out_HL;
   logic        acc_clear;
   logic [15:0] stall_cnt;

   tpu_operand_feeder #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .hold      (hold),
      .input1    (input1),
      .input2    (input2),
      .out_HL    (out_HL),
      .acc_clear (acc_clear),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: queue of pending pairs {a,b,last}, and a count of
   // non-popping cycles still owed to the strobe/clear sequence.
   logic [16:0] m_q[$];
   int          m_gap;
   logic [7:0]  m_in1, m_in2;
   logic        m_hl, m_clr;
   logic [15:0] m_stall;
   int          mac_acc;
   int          mac_captured;
   int          n_strobes;

   function automatic logic [7:0] norm(input logic [7:0] v);
      return (v == 8'h80) ? 8'h00 : v;
   endfunction

   function automatic int sm_val(input logic [7:0] v);
      int mag;
      mag = int'(v[6:0]);
      return v[7] ? -mag : mag;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_gap = 0;
      m_in1 = 8'h00; m_in2 = 8'h00;
      m_hl = 1'b0; m_clr = 1'b0;
      m_stall = 16'h0000;
      mac_acc = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".input1"},    {8'h00, input1},    {8'h00, m_in1});
      chk({tag, ".input2"},    {8'h00, input2},    {8'h00, m_in2});
      chk({tag, ".out_HL"},    {15'h0, out_HL},    {15'h0, m_hl});
      chk({tag, ".acc_clear"}, {15'h0, acc_clear}, {15'h0, m_clr});
      chk({tag, ".stall_cnt"}, stall_cnt,          m_stall);
   endtask

   // One clock cycle: drive inputs, check in_ready, advance model and DUT.
   task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic l, input logic h);
      logic        push, pop, idle;
      logic [16:0] head;
      in_valid = v; in_a = a; in_b = b; in_last = l; hold = h;
      #1;
      chk("in_ready", {15'h0, in_ready}, {15'h0, (m_q.size() < DEPTH)});
      push = v && (m_q.size() < DEPTH);
      pop  = (m_gap == 0) && (m_q.size() > 0) && !h;
      idle = (m_gap == 0) && (m_q.size() == 0) && !h;
      head = (m_q.size() > 0) ? m_q[0] : 17'h0;
      m_hl  = (m_gap == 2);
      m_clr = (m_gap == 1);
      m_in1 = pop ? norm(head[16:9]) : 8'h00;
      m_in2 = pop ? norm(head[8:1])  : 8'h00;
`ifdef FEEDER_STALL_CNT_EN
      if (idle && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
      if (pop) void'(m_q.pop_front());
      if (pop && head[0])  m_gap = 2;
      else if (m_gap > 0)  m_gap = m_gap - 1;
      if (push) m_q.push_back({a, b, l});
      @(posedge clk);
      #1;
      check_outputs("cyc");
      if (out_HL) begin
         mac_captured = mac_acc;
         n_strobes++;
      end
      mac_acc += sm_val(input1) * sm_val(input2);
      if (acc_clear) mac_acc = 0;
   endtask

   task automatic idle_steps(input int n, input logic h);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, h);
   endtask

   initial begin
      int exp_mac;
      in_valid = 0; in_a = 0; in_b = 0; in_last = 0; hold = 0;
      n_strobes = 0; mac_captured = 0;
      reset = 1'b0;
      model_reset();
      #12;
      check_outputs("reset");
      chk("reset.in_ready", {15'h0, in_ready}, 16'h0001);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Single last pair: operands, then strobe, then clear (hold ignored after pop)
      step(1'b1, 8'h0D, 8'h0F, 1'b1, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("single.input1", {8'h00, input1}, 16'h000D);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      chk("single.out_HL", {15'h0, out_HL}, 16'h0001);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      chk("single.acc_clear", {15'h0, acc_clear}, 16'h0001);
      idle_steps(2, 1'b0);

      // Three-pair vector back to back; MAC result from observed operands
      n_strobes = 0;
      step(1'b1, 8'h0D, 8'h0F, 1'b0, 1'b0);
      step(1'b1, 8'h29, 8'h2F, 1'b0, 1'b0);
      step(1'b1, 8'h89, 8'h09, 1'b1, 1'b0);
      idle_steps(5, 1'b0);
      exp_mac = sm_val(8'h0D) * sm_val(8'h0F) + sm_val(8'h29) * sm_val(8'h2F)
              + sm_val(8'h89) * sm_val(8'h09);
      chk("vec3.mac", 16'(mac_captured), 16'(exp_mac));
      chk("vec3.strobes", 16'(n_strobes), 16'd1);

      // Fill under hold, then drain; in_ready must drop at full
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 8'(8'h10 + i), 8'(8'h20 + i), (i == DEPTH - 1), 1'b1);
      chk("full.in_ready", {15'h0, in_ready}, 16'h0000);
      step(1'b1, 8'h77, 8'h77, 1'b0, 1'b1);
      idle_steps(DEPTH + 4, 1'b0);

      // Negative zero normalisation
      step(1'b1, 8'h80, 8'h05, 1'b1, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("negzero.input2", {8'h00, input2}, 16'h0005);
      idle_steps(3, 1'b0);

      // Idle stall counting with and without hold
      idle_steps(10, 1'b0);
      idle_steps(5, 1'b1);

      // Reset during STROBE with two pairs buffered
      n_strobes = 0;
      step(1'b1, 8'h11, 8'h12, 1'b1, 1'b1);
      step(1'b1, 8'h13, 8'h14, 1'b0, 1'b1);
      step(1'b1, 8'h15, 8'h16, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_outputs("midreset");
      chk("midreset.in_ready", {15'h0, in_ready}, 16'h0001);
      @(posedge clk); #3;
      reset = 1'b1;
      idle_steps(6, 1'b0);
      chk("midreset.no_strobe", 16'(n_strobes), 16'd0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      idle_steps(DEPTH * 4, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
